// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port for mips_multicycle_core.
// A transfer completes in any cycle where mem_req and mem_ready are both high.
interface mips_multicycle_core_if #(
  parameter int MEM_AW = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, one valid/ready memory port.
// Define ADD_OVF_EN to decode add/sub/addi with a sticky signed-overflow flag.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          MEM_AW   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_core_if.master mem,
  output logic [31:0]            pc_o,
  output logic                   retire,
  output logic                   halted,
  output logic                   ovf
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                         FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;

  typedef struct packed {
    logic    legal;
    alu_op_e alu_op;
    logic    use_imm;
    logic    imm_zext;
    logic    wr_rt;
    logic    is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
  } dec_t;

  state_e      state, state_n;
  logic [31:0] pc, pc_n, ir, a, b, alu_out, mdr, tgt;
  logic [31:0] gpr [32];
  logic        mem_req_q, xfer;
  logic        gpr_we, wb_kill;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  dec_t        dec;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] pc_plus4, imm_ext, alu_b, alu_sum, alu_diff, alu_y, mem_word;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    unique case (opcode)
      OP_R: begin
        unique case (funct)
          FN_ADDU: begin dec.legal = 1'b1; dec.alu_op = ALU_ADD; end
          FN_SUBU: begin dec.legal = 1'b1; dec.alu_op = ALU_SUB; end
          FN_AND:  begin dec.legal = 1'b1; dec.alu_op = ALU_AND; end
          FN_OR:   begin dec.legal = 1'b1; dec.alu_op = ALU_OR;  end
          FN_SLT:  begin dec.legal = 1'b1; dec.alu_op = ALU_SLT; end
          FN_JR:   begin dec.legal = 1'b1; dec.is_jr  = 1'b1;    end
`ifdef ADD_OVF_EN
          FN_ADD:  begin dec.legal = 1'b1; dec.alu_op = ALU_ADD; end
          FN_SUB:  begin dec.legal = 1'b1; dec.alu_op = ALU_SUB; end
`endif
          default: ;
        endcase
      end
      OP_ORI: begin
        dec.legal = 1'b1; dec.alu_op = ALU_OR; dec.use_imm = 1'b1;
        dec.imm_zext = 1'b1; dec.wr_rt = 1'b1;
      end
      OP_LUI: begin dec.legal = 1'b1; dec.alu_op = ALU_LUI; dec.wr_rt = 1'b1; end
      OP_LW:  begin dec.legal = 1'b1; dec.use_imm = 1'b1; dec.is_lw = 1'b1; dec.wr_rt = 1'b1; end
      OP_SW:  begin dec.legal = 1'b1; dec.use_imm = 1'b1; dec.is_sw = 1'b1; end
      OP_BEQ: begin dec.legal = 1'b1; dec.is_beq = 1'b1; end
      OP_J:   begin dec.legal = 1'b1; dec.is_j   = 1'b1; end
      OP_JAL: begin dec.legal = 1'b1; dec.is_jal = 1'b1; end
`ifdef ADD_OVF_EN
      OP_ADDI: begin dec.legal = 1'b1; dec.use_imm = 1'b1; dec.wr_rt = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Shared ALU; lui ignores A and shifts the raw immediate.
  assign imm_ext  = dec.imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign alu_b    = dec.use_imm ? imm_ext : b;
  assign alu_sum  = a + alu_b;
  assign alu_diff = a - alu_b;

  always_comb begin
    alu_y = alu_sum;
    unique case (dec.alu_op)
      ALU_ADD: alu_y = alu_sum;
      ALU_SUB: alu_y = alu_diff;
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(a) < $signed(alu_b)};
      ALU_LUI: alu_y = {imm, 16'h0};
      default: alu_y = alu_sum;
    endcase
  end

  assign xfer     = mem_req_q & mem.mem_ready;
  assign mem_word = (state == S_MEM) ? alu_out : pc;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_req_q && (state == S_MEM) && dec.is_sw;
  assign mem.mem_addr  = {mem_word[MEM_AW-1:2], 2'b00};
  assign mem.mem_wdata = b;

  assign pc_o   = pc;
  assign halted = (state == S_HALT);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    retire  = 1'b0;
    gpr_we  = 1'b0;
    gpr_wa  = 5'd0;
    gpr_wd  = 32'h0;
    unique case (state)
      S_FETCH:  if (xfer) state_n = S_DECODE;
      S_DECODE: state_n = dec.legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (dec.is_beq) begin
          pc_n    = (a == b) ? tgt : pc_plus4;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else if (dec.is_j || dec.is_jal) begin
          pc_n    = {pc_plus4[31:28], ir[25:0], 2'b00};
          retire  = 1'b1;
          state_n = S_FETCH;
          gpr_we  = dec.is_jal;
          gpr_wa  = 5'd31;
          gpr_wd  = pc_plus4;
        end else if (dec.is_jr) begin
          pc_n    = a;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else if (dec.is_lw || dec.is_sw) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (xfer) begin
          if (dec.is_sw) begin
            pc_n    = pc_plus4;
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        pc_n    = pc_plus4;
        retire  = 1'b1;
        state_n = S_FETCH;
        gpr_we  = !wb_kill;
        gpr_wa  = dec.wr_rt ? rt : rd;
        gpr_wd  = dec.is_lw ? mdr : alu_out;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  // mem_req is registered from the next state so it is glitch-free and
  // drops the instant reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      mem_req_q <= 1'b0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      tgt       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      mem_req_q <= (state_n == S_FETCH) || (state_n == S_MEM);
      if (state == S_FETCH && xfer) ir <= mem.mem_rdata;
      if (state == S_DECODE) begin
        a   <= gpr[rs];
        b   <= gpr[rt];
        tgt <= pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
      end
      if (state == S_EXEC) alu_out <= alu_y;
      if (state == S_MEM && xfer && dec.is_lw) mdr <= mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (gpr_we && gpr_wa != 5'd0) begin
      gpr[gpr_wa] <= gpr_wd;
    end
  end

`ifdef ADD_OVF_EN
  logic ovf_op, alu_v, ovf_pend, ovf_q;

  assign ovf_op = ((opcode == OP_R) && (funct == FN_ADD || funct == FN_SUB)) ||
                  (opcode == OP_ADDI);
  assign alu_v  = (dec.alu_op == ALU_SUB) ?
                  ((a[31] != alu_b[31]) && (alu_diff[31] != a[31])) :
                  ((a[31] == alu_b[31]) && (alu_sum[31]  != a[31]));

  // Overflow is captured in EXEC and acted on in WB: the write is dropped
  // but the instruction still retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == S_EXEC) ovf_pend <= ovf_op & alu_v;
      if (state == S_WB && ovf_pend) ovf_q <= 1'b1;
    end
  end

  assign wb_kill = ovf_pend;
  assign ovf     = ovf_q;
`else
  assign wb_kill = 1'b0;
  assign ovf     = 1'b0;
`endif
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs run against a
// wait-state memory model; stores, fetch order and retire timing are checked.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_o;
  logic        retire, halted, ovf;

  mips_multicycle_core_if #(.MEM_AW(32)) mif ();

  mips_multicycle_core #(.RESET_PC(32'h0000_3000), .MEM_AW(32)) dut (
    .clk(clk), .reset(reset), .mem(mif), .pc_o(pc_o),
    .retire(retire), .halted(halted), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Memory: program words at 0x3000+, data below 0x1000 with data_wait stalls.
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          data_wait;
  int          wcnt;
  logic        is_data;

  assign is_data = mif.mem_addr < 32'h1000;
  always_comb mif.mem_ready = is_data ? (wcnt >= data_wait) : 1'b1;
  always_comb mif.mem_rdata = is_data ? dmem[mif.mem_addr[7:2]] : imem[mif.mem_addr[7:2]];

  always @(posedge clk) begin
    if (reset) wcnt <= 0;
    else if (mif.mem_req && mif.mem_ready) begin
      wcnt <= 0;
      if (mif.mem_we) dmem[mif.mem_addr[7:2]] <= mif.mem_wdata;
    end else if (mif.mem_req) wcnt <= wcnt + 1;
  end

  // Monitor: transfers, retire cycles, request stability while stalled.
  logic [31:0]  fetch_q [$];
  logic [63:0]  wr_q [$];
  int unsigned  ret_q [$];
  int unsigned  cyc;
  int           hold_bad;
  logic         pw;
  logic [64:0]  prev, cur;

  assign cur = {mif.mem_we, mif.mem_addr, mif.mem_wdata};

  always @(negedge clk) begin
    if (reset) begin
      fetch_q.delete(); wr_q.delete(); ret_q.delete();
      cyc <= 0; hold_bad <= 0; pw <= 1'b0; prev <= '0;
    end else begin
      cyc <= cyc + 1;
      if (retire) ret_q.push_back(cyc);
      if (mif.mem_req && mif.mem_ready) begin
        if (mif.mem_we) wr_q.push_back({mif.mem_addr, mif.mem_wdata});
        else if (mif.mem_addr >= 32'h3000) fetch_q.push_back(mif.mem_addr);
      end
      if (pw && mif.mem_req && cur != prev) hold_bad <= hold_bad + 1;
      pw   <= mif.mem_req && !mif.mem_ready;
      prev <= cur;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] prog_a [16] = '{
    32'h34011234, 32'h3C02ABCD, 32'h00221821, 32'hAC030008,
    32'h8C040008, 32'hAC04000C, 32'h00222823, 32'h0041302A,
    32'h00613824, 32'hAC050010, 32'hAC060014, 32'hAC070018,
    32'h34000005, 32'hAC00001C, 32'hFC000000, 32'hFC000000};
  logic [63:0] exp_a [6] = '{
    {32'd8,  32'hABCD1234}, {32'd12, 32'hABCD1234}, {32'd16, 32'h54331234},
    {32'd20, 32'h00000001}, {32'd24, 32'h00001234}, {32'd28, 32'h00000000}};

  logic [31:0] prog_b [16] = '{
    32'h13E00001, 32'h03E00008, 32'h34010005, 32'h34020005,
    32'h08000C06, 32'h08000C07, 32'h1022FFFE, 32'h10200005,
    32'h0C000C00, 32'hAC1F0000, 32'hFC000000, 32'hFC000000,
    32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000};
  logic [31:0] exp_b [12] = '{
    32'h3000, 32'h3008, 32'h300C, 32'h3010, 32'h3018, 32'h3014,
    32'h301C, 32'h3020, 32'h3000, 32'h3004, 32'h3024, 32'h3028};

  logic [31:0] prog_c [16] = '{
    32'h3C017FFF, 32'h3421FFFF, 32'h34020001, 32'h34030063,
    32'h00221820, 32'hAC030000, 32'hFC000000, 32'hFC000000,
    32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000,
    32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000};

  task automatic load(input logic [31:0] w [16]);
    for (int i = 0; i < 64; i++) imem[i] = (i < 16) ? w[i] : 32'hFC000000;
  endtask

  task automatic start(input logic [31:0] w [16], input int dw);
    reset = 1'b1;
    load(w);
    data_wait = dw;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mif.mem_req) begin n = i; break; end
    end
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk({"halt_", tag}, halted, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, found;
    reset = 1'b1;
    data_wait = 0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;

    // Reset state and first request, then arithmetic/load/store program.
    load(prog_a);
    data_wait = 2;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h3000);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_we", mif.mem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    wait_req(lat);
    chk("req_lat", lat, 1);
    chk("req_addr", mif.mem_addr, 32'h3000);
    chk("req_we", mif.mem_we, 0);
    chk("req_halted", halted, 0);
    run_to_halt("a");
    chk("a_nwr", wr_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("a_wr%0d", i), wr_q[i], exp_a[i]);
    chk("a_nret", ret_q.size(), 14);
    chk("a_ori_lui", ret_q[1] - ret_q[0], 4);
    chk("a_lui_addu", ret_q[2] - ret_q[1], 4);
    chk("a_sw_lat", ret_q[3] - ret_q[2], 6);
    chk("a_lw_lat", ret_q[4] - ret_q[3], 7);
    chk("a_hold", hold_bad, 0);
    repeat (4) @(negedge clk);
    chk("a_halt_noreq", mif.mem_req, 0);
    chk("a_halt_sticky", halted, 1);
    chk("a_ovf", ovf, 0);

    // Branches and jumps: fetch order and the jal link value.
    start(prog_b, 2);
    run_to_halt("b");
    chk("b_nfetch", fetch_q.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("b_fetch%0d", i), fetch_q[i], exp_b[i]);
    chk("b_nwr", wr_q.size(), 1);
    chk("b_link", wr_q[0], {32'd0, 32'h00003024});
    chk("b_nret", ret_q.size(), 11);
    chk("b_hold", hold_bad, 0);

    // Signed add of 0x7FFFFFFF + 1.
    start(prog_c, 0);
    run_to_halt("c");
`ifdef ADD_OVF_EN
    chk("c_ovf", ovf, 1);
    chk("c_nwr", wr_q.size(), 1);
    chk("c_dest_kept", wr_q[0], {32'd0, 32'h00000063});
    chk("c_nret", ret_q.size(), 6);
    chk("c_nfetch", fetch_q.size(), 7);
`else
    chk("c_ovf", ovf, 0);
    chk("c_nwr", wr_q.size(), 0);
    chk("c_nret", ret_q.size(), 4);
    chk("c_nfetch", fetch_q.size(), 5);
    chk("c_last_fetch", fetch_q[fetch_q.size()-1], 32'h3010);
`endif

    // Reset while a store is stalled: the request drops at once.
    start(prog_a, 6);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mif.mem_req && mif.mem_we) begin found = 1; break; end
    end
    chk("d_sw_pending", found, 1);
    chk("d_sw_addr", mif.mem_addr, 32'd8);
    reset = 1'b1;
    #1;
    chk("d_req_drop", mif.mem_req, 0);
    chk("d_we_drop", mif.mem_we, 0);
    chk("d_pc", pc_o, 32'h3000);
    chk("d_retire", retire, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_req(lat);
    chk("d_refetch_lat", lat, 1);
    chk("d_refetch_addr", mif.mem_addr, 32'h3000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle MIPS core that succeeds the single-cycle top. It replaces the one-instruction-per-clock datapath with a five-state controller sharing one ALU and one memory port. That memory port is a unified instruction/data port with a valid/ready handshake, so the core tolerates variable-latency memory. The core sits between the testbench/SoC top and a single external memory model; register file and ALU are internal.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- MEM_AW, 32, width of mem_addr; upper bits beyond MEM_AW are dropped from the byte address.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (sw), 0 = read (fetch or lw).
- mem_addr  out  MEM_AW  byte address, word aligned (bits [1:0] = 0).
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready is high.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- pc_o  out  32  PC of the instruction in flight.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; set on illegal opcode.
- ovf  out  1  sticky overflow flag (only with ADD_OVF_EN; otherwise tied 0).

## Operation
- Supported instructions: addu, subu, and, or, slt, jr (R-type); ori, lui, lw, sw, beq, j, jal. With ADD_OVF_EN, add, sub and addi are also supported.
- Any other opcode/funct → HALT.
- The register file is 32x32. $0 reads 0 and writes to it are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=pc; wait while mem_ready=0.
  - On mem_ready, latch IR←mem_rdata and go to DECODE.
- DECODE:
  - Latch A←GPR[rs], B←GPR[rt].
  - Compute sign-extended branch target pc+4+(imm<<2).
  - Go to EXEC, or to HALT if the instruction is illegal.
- EXEC:
  - ALU operands are A and either B or the extended immediate. ori uses zero-extend; addi, lw, sw and beq use sign-extend; lui computes imm<<16.
  - beq: pc←A==B ? target : pc+4; retire; go to FETCH.
  - j: pc←{pc[31:28]+carry-free of pc+4, instr_index, 2'b00}; retire; go to FETCH.
  - jal: same target as j, plus GPR[31]←pc+4; retire; go to FETCH.
  - jr: pc←A; retire; go to FETCH.
  - lw/sw: latch ALUOut and go to MEM.
  - All other instructions: go to WB.
- MEM:
  - Drive mem_req=1, mem_addr=ALUOut; for sw also mem_we=1, mem_wdata=B. Wait for mem_ready.
  - sw: pc←pc+4; retire; go to FETCH.
  - lw: MDR←mem_rdata; go to WB.
- WB:
  - Destination is rd for R-type, rt for I-type. Data is MDR for lw, ALUOut otherwise.
  - pc←pc+4; retire; go to FETCH.
- HALT: no requests; halted=1 until reset.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_ready is ignored when mem_req=0.
  - A transfer completes in any cycle where mem_req and mem_ready are both high.
- Arithmetic: all operations are 32-bit. addu/subu wrap. slt is signed. beq compares all 32 bits.

## Timing
- Reset values (asynchronous): state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, mem_req=0, mem_we=0, retire=0, halted=0, ovf=0.
- Registers in the GPR file are all 0 after reset.
- mem_req is asserted in the first rising-edge cycle after reset deasserts.
- Latency with zero-wait memory (mem_ready tied 1):
  - beq/j/jal/jr: 3 cycles.
  - R-type/ori/lui: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on mem_ready adds 1 cycle.
- retire is high in the final cycle of an instruction, and pc_o updates on the following edge.
- Reset asserted mid-request: mem_req drops combinationally-from-register immediately. Any in-progress write is abandoned and the GPR file is not written.
- A GPR write and a read of the same register never overlap, because DECODE of the next instruction is at least 2 cycles after WB.

## Configuration
- ADD_OVF_EN defined:
  - add/sub/addi are decoded.
  - On signed overflow, the register write is suppressed, ovf sets (sticky), pc advances and the instruction retires.
- ADD_OVF_EN undefined:
  - add/sub/addi are illegal and go to HALT.
  - ovf is constant 0.

## Test plan
- Reset with RESET_PC=32'h3000 and mem_ready=1 → first mem_req has mem_addr=32'h3000, mem_we=0. halted=0.
- ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 → $3=32'hABCD1234. Retire pulses arrive 4 cycles apart.
- sw $3,8($0) then lw $4,8($0), with mem_ready held low 2 cycles per access:
  - Write transfer shows addr=8, wdata=32'hABCD1234.
  - $4=32'hABCD1234.
  - lw takes 7 cycles.
- beq with equal operands and offset -2 at pc=32'h3010 → next fetch at 32'h300C. Unequal operands → next fetch at 32'h3014.
- jal at 32'h3020 to index 0x0C00 → $31=32'h3024, next fetch 32'h3000. A following jr $31 → fetch 32'h3024.
- Word 32'hFC000000 fetched → halted=1 and mem_req stays 0. With ADD_OVF_EN, add of 32'h7FFFFFFF+1 → ovf=1 and the destination is unchanged.
